// File: rtl/vga_column_scheduler_if.sv
// vga_column_scheduler_if: column-in / rectangle-command-out bundle of the column scheduler.
interface vga_column_scheduler_if;
    logic       frame_start;
    logic       col_valid;
    logic [7:0] col_height;
    logic [2:0] col_color;
    logic       col_ready;
    logic       draw_start;
    logic [7:0] draw_X;
    logic [6:0] draw_Y;
    logic [7:0] draw_size;
    logic [2:0] draw_color;
    logic       draw_done;
    logic       busy;
    logic       frame_done;
    logic [4:0] col_index;
    modport master (
        input  frame_start, col_valid, col_height, col_color, draw_done,
        output col_ready, draw_start, draw_X, draw_Y, draw_size, draw_color, busy, frame_done, col_index
    );
    modport slave (
        output frame_start, col_valid, col_height, col_color, draw_done,
        input  col_ready, draw_start, draw_X, draw_Y, draw_size, draw_color, busy, frame_done, col_index
    );
endinterface

// File: rtl/vga_column_scheduler.sv
// vga_column_scheduler: splits each column into ceiling/wall/floor rectangle commands, one in flight.
// Optional VGA_SCHED_SKIP_UNCHANGED_EN: skip columns whose {height, colour} match the last drawn frame.
module vga_column_scheduler #(
    parameter int         NUM_COLS    = 32,
    parameter int         COL_W       = 4,
    parameter int         SCREEN_H    = 128,
    parameter logic [2:0] CEIL_COLOR  = 3'b001,
    parameter logic [2:0] FLOOR_COLOR = 3'b010
) (
    input  logic                          clock,
    input  logic                          resetn,
    vga_column_scheduler_if.master        bus
`ifdef VGA_SCHED_SKIP_UNCHANGED_EN
    ,
    output logic [7:0]                    skip_count
`endif
);
    typedef enum logic [3:0] {
        IDLE, FETCH, CEIL_ISSUE, CEIL_WAIT, WALL_ISSUE, WALL_WAIT,
        FLOOR_ISSUE, FLOOR_WAIT, NEXT, DONE
    } state_t;

    state_t      state_q;
    logic [7:0]  h_q, bot_q, x_q, size_q;
    logic [6:0]  top_q, y_q;
    logic [2:0]  color_q, dcol_q;
    logic [4:0]  col_q;
    logic        busy_q, frame_done_q, draw_start_q;
    logic [7:0]  hc, bot_c, x_c;
    logic [6:0]  top_c;
    logic        done_ok;

    assign hc      = (bus.col_height > 8'(SCREEN_H)) ? 8'(SCREEN_H) : bus.col_height;
    assign top_c   = 7'((8'(SCREEN_H) - hc) >> 1);
    assign bot_c   = 8'(SCREEN_H) - {1'b0, top_c} - hc;
    assign x_c     = 8'(32'(col_q) * COL_W);
    // a completion coinciding with the issue pulse belongs to no command yet
    assign done_ok = bus.draw_done && !draw_start_q;

`ifdef VGA_SCHED_SKIP_UNCHANGED_EN
    logic [10:0] tbl_q [NUM_COLS];
    logic [7:0]  skip_q;
    logic        match;
    assign match      = tbl_q[col_q] == {hc, bus.col_color};
    assign skip_count = skip_q;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            h_q          <= '0;
            bot_q        <= '0;
            top_q        <= '0;
            color_q      <= '0;
            col_q        <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            draw_start_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            size_q       <= '0;
            dcol_q       <= '0;
`ifdef VGA_SCHED_SKIP_UNCHANGED_EN
            skip_q       <= '0;
            for (int i = 0; i < NUM_COLS; i++) tbl_q[i] <= '0;
`endif
        end else begin
            draw_start_q <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.frame_start) begin
                    col_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= FETCH;
`ifdef VGA_SCHED_SKIP_UNCHANGED_EN
                    skip_q  <= '0;
`endif
                end
                FETCH: if (bus.col_valid) begin
                    h_q     <= hc;
                    color_q <= bus.col_color;
                    top_q   <= top_c;
                    bot_q   <= bot_c;
`ifdef VGA_SCHED_SKIP_UNCHANGED_EN
                    state_q <= match ? NEXT : CEIL_ISSUE;
                    if (match && skip_q != 8'hFF) skip_q <= skip_q + 8'd1;
`else
                    state_q <= CEIL_ISSUE;
`endif
                end
                CEIL_ISSUE: begin
                    state_q <= (top_q != 0) ? CEIL_WAIT : WALL_ISSUE;
                    if (top_q != 0) begin
                        x_q          <= x_c;
                        y_q          <= '0;
                        size_q       <= {1'b0, top_q};
                        dcol_q       <= CEIL_COLOR;
                        draw_start_q <= 1'b1;
                    end
                end
                CEIL_WAIT: if (done_ok) state_q <= WALL_ISSUE;
                WALL_ISSUE: begin
                    state_q <= (h_q != 0) ? WALL_WAIT : FLOOR_ISSUE;
                    if (h_q != 0) begin
                        x_q          <= x_c;
                        y_q          <= top_q;
                        size_q       <= h_q;
                        dcol_q       <= color_q;
                        draw_start_q <= 1'b1;
                    end
                end
                WALL_WAIT: if (done_ok) state_q <= FLOOR_ISSUE;
                FLOOR_ISSUE: begin
                    state_q <= (bot_q != 0) ? FLOOR_WAIT : NEXT;
                    if (bot_q != 0) begin
                        x_q          <= x_c;
                        y_q          <= 7'({1'b0, top_q} + h_q);
                        size_q       <= bot_q;
                        dcol_q       <= FLOOR_COLOR;
                        draw_start_q <= 1'b1;
                    end
`ifdef VGA_SCHED_SKIP_UNCHANGED_EN
                    else tbl_q[col_q] <= {h_q, color_q};
`endif
                end
                FLOOR_WAIT: if (done_ok) begin
                    state_q <= NEXT;
`ifdef VGA_SCHED_SKIP_UNCHANGED_EN
                    tbl_q[col_q] <= {h_q, color_q};
`endif
                end
                NEXT: begin
                    if (col_q == 5'(NUM_COLS - 1)) begin
                        state_q      <= DONE;
                        frame_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                    end else begin
                        col_q   <= col_q + 5'd1;
                        state_q <= FETCH;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.col_ready  = state_q == FETCH;
    assign bus.draw_start = draw_start_q;
    assign bus.draw_X     = x_q;
    assign bus.draw_Y     = y_q;
    assign bus.draw_size  = size_q;
    assign bus.draw_color = dcol_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.col_index  = col_q;
endmodule

// File: tb/tb_vga_column_scheduler.sv
// tb_vga_column_scheduler: scoreboard bench with an engine model answering every draw command.
module tb_vga_column_scheduler;
    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [7:0] size;
        logic [2:0] color;
    } cmd_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    vga_column_scheduler_if bus();
`ifdef VGA_SCHED_SKIP_UNCHANGED_EN
    logic [7:0] skip_count;
    int tbl[32];
    int exp_skips = 0;
`endif

    vga_column_scheduler dut (
        .clock(clk),
        .resetn(resetn),
        .bus(bus)
`ifdef VGA_SCHED_SKIP_UNCHANGED_EN
        ,
        .skip_count(skip_count)
`endif
    );

    always #5 clk = ~clk;

    int   checks = 0, fails = 0, pulses = 0, frames = 0, exp_cmds = 0;
    int   done_delay = 0, wait_left = 0;
    bit   in_flight = 0, early_done = 0;
    cmd_t cur, got, e;
    cmd_t exp_q[$];
    int   hts[32], cls[32];

    // engine model and scoreboard consumer
    always @(negedge clk) begin
        bus.draw_done = 1'b0;
        got = '{bus.draw_X, bus.draw_Y, bus.draw_size, bus.draw_color};
        if (!resetn) in_flight = 0;
        else begin
            if (bus.frame_done) frames++;
            if (in_flight) begin
                checks++;
                if (got !== cur) begin fails++; $display("FAIL field_stable got %h want %h", got, cur); end
                if (bus.draw_start) begin fails++; $display("FAIL overlap pulse while command in flight"); end
                if (wait_left == 0) begin bus.draw_done = 1'b1; in_flight = 0; end
                else wait_left--;
            end
            if (bus.draw_start) begin
                pulses++;
                checks++;
                if (exp_q.size() == 0) begin fails++; $display("FAIL extra_pulse got %h want none", got); end
                else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin fails++; $display("FAIL cmd got x=%0d y=%0d s=%0d c=%0d want x=%0d y=%0d s=%0d c=%0d", got.x, got.y, got.size, got.color, e.x, e.y, e.size, e.color); end
                end
                cur = got;
                in_flight = 1;
                wait_left = done_delay;
                if (early_done) bus.draw_done = 1'b1;
            end
        end
    end

    function automatic void push_col(int c, int h, int col);
        int hc, top, bot;
        hc  = h > 128 ? 128 : h;
        top = (128 - hc) / 2;
        bot = 128 - top - hc;
`ifdef VGA_SCHED_SKIP_UNCHANGED_EN
        if (tbl[c] == hc * 8 + col) begin exp_skips++; return; end
        tbl[c] = hc * 8 + col;
`endif
        if (top > 0) begin exp_q.push_back(cmd_t'{8'(c * 4), 7'(0), 8'(top), 3'b001}); exp_cmds++; end
        if (hc > 0)  begin exp_q.push_back(cmd_t'{8'(c * 4), 7'(top), 8'(hc), 3'(col)}); exp_cmds++; end
        if (bot > 0) begin exp_q.push_back(cmd_t'{8'(c * 4), 7'(top + hc), 8'(bot), 3'b010}); exp_cmds++; end
    endfunction

    task automatic test_reset;
        bus.frame_start = 0; bus.col_valid = 0; bus.col_height = 0; bus.col_color = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.draw_start, bus.frame_done, bus.col_ready, bus.col_index} !== 9'd0) begin
            fails++; $display("FAIL reset_ctrl got %b want 0", {bus.busy, bus.draw_start, bus.frame_done, bus.col_ready, bus.col_index});
        end
        checks++;
        if ({bus.draw_X, bus.draw_Y, bus.draw_size, bus.draw_color} !== 26'd0) begin
            fails++; $display("FAIL reset_fields got %h want 0", {bus.draw_X, bus.draw_Y, bus.draw_size, bus.draw_color});
        end
`ifdef VGA_SCHED_SKIP_UNCHANGED_EN
        checks++;
        if (skip_count !== 8'd0) begin fails++; $display("FAIL reset_skip got %0d want 0", skip_count); end
`endif
        resetn = 1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wall;
        int n;
        done_delay = 20; early_done = 0; exp_cmds = 0;
        bus.frame_start = 1; @(negedge clk); bus.frame_start = 0;
        bus.col_valid = 1; bus.col_height = 8'd40; bus.col_color = 3'b100;
        push_col(0, 40, 4);
        n = 0;
        while (!bus.col_ready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk); bus.col_valid = 0;
        n = 0;
        while (!(in_flight && cur.y == 7'd44) && n < 500) begin @(negedge clk); n++; end
        checks++;
        if (!(in_flight && cur.y == 7'd44)) begin fails++; $display("FAIL reach_wall_wait got y=%0d want 44", cur.y); end
        #2 resetn = 0;
        #1;
        checks++;
        if ({bus.busy, bus.draw_start, bus.frame_done, bus.col_ready, bus.col_index} !== 9'd0) begin
            fails++; $display("FAIL async_reset_ctrl got %b want 0", {bus.busy, bus.draw_start, bus.frame_done, bus.col_ready, bus.col_index});
        end
        checks++;
        if ({bus.draw_X, bus.draw_Y, bus.draw_size, bus.draw_color} !== 26'd0) begin
            fails++; $display("FAIL async_reset_fields got %h want 0", {bus.draw_X, bus.draw_Y, bus.draw_size, bus.draw_color});
        end
        exp_q.delete();
`ifdef VGA_SCHED_SKIP_UNCHANGED_EN
        foreach (tbl[i]) tbl[i] = 0;
`endif
        repeat (3) @(negedge clk);
        resetn = 1;
        repeat (4) @(negedge clk);
        checks++;
        if ({bus.busy, bus.draw_start, bus.col_ready} !== 3'd0) begin
            fails++; $display("FAIL post_reset_idle got %b want 000", {bus.busy, bus.draw_start, bus.col_ready});
        end
    endtask

    task automatic run_frame(input string name, input int gap, input int dly, input bit early, input bit poke);
        int n, p0, f0;
        bit last_busy;
        done_delay = dly; early_done = early; exp_cmds = 0; p0 = pulses; f0 = frames;
`ifdef VGA_SCHED_SKIP_UNCHANGED_EN
        exp_skips = 0;
`endif
        bus.frame_start = 1; @(negedge clk); bus.frame_start = 0;
        checks++;
        if (bus.busy !== 1'b1 || bus.col_index !== 5'd0) begin
            fails++; $display("FAIL %s start got busy=%b idx=%0d want 1 0", name, bus.busy, bus.col_index);
        end
        for (int c = 0; c < 32; c++) begin
            bus.col_valid = 0;
            if (poke && c == 3) begin bus.frame_start = 1; @(negedge clk); bus.frame_start = 0; end
            repeat (gap) @(negedge clk);
            bus.col_valid = 1; bus.col_height = 8'(hts[c]); bus.col_color = 3'(cls[c]);
            push_col(c, hts[c], cls[c]);
            n = 0;
            while (!bus.col_ready && n < 2000) begin @(negedge clk); n++; end
            checks++;
            if (!bus.col_ready) begin fails++; $display("FAIL %s col_ready_timeout col %0d", name, c); bus.col_valid = 0; return; end
            checks++;
            if (bus.col_index !== 5'(c)) begin fails++; $display("FAIL %s col_index got %0d want %0d", name, bus.col_index, c); end
            @(negedge clk);
            bus.col_valid = 0;
        end
        n = 0; last_busy = bus.busy;
        while (!bus.frame_done && n < 5000) begin last_busy = bus.busy; @(negedge clk); n++; end
        checks++;
        if (!bus.frame_done) begin fails++; $display("FAIL %s frame_done_timeout got 0 want 1", name); end
        checks++;
        if (bus.busy !== 1'b0 || last_busy !== 1'b1) begin
            fails++; $display("FAIL %s busy_fall got busy=%b prev=%b want 0 1", name, bus.busy, last_busy);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (frames - f0 != 1) begin fails++; $display("FAIL %s frame_done_count got %0d want 1", name, frames - f0); end
        checks++;
        if (pulses - p0 != exp_cmds || exp_q.size() != 0) begin
            fails++; $display("FAIL %s pulse_count got %0d want %0d (left %0d)", name, pulses - p0, exp_cmds, exp_q.size());
        end
`ifdef VGA_SCHED_SKIP_UNCHANGED_EN
        checks++;
        if (skip_count !== 8'(exp_skips)) begin fails++; $display("FAIL %s skip_count got %0d want %0d", name, skip_count, exp_skips); end
`endif
    endtask

    task automatic test_directed_frame;
        foreach (hts[i]) begin hts[i] = $urandom_range(0, 255); cls[i] = $urandom_range(0, 7); end
        hts[0] = 40;  cls[0] = 4;
        hts[1] = 0;   cls[1] = 3;
        hts[2] = 41;  cls[2] = 5;
        hts[5] = 200; cls[5] = 6;
        hts[31] = 128; cls[31] = 7;
        run_frame("directed", 0, 0, 1, 0);
    endtask

    task automatic test_valid_gap;
        foreach (hts[i]) begin hts[i] = $urandom_range(0, 140); cls[i] = $urandom_range(0, 7); end
        run_frame("valid_gap", 10, 2, 0, 1);
    endtask

    task automatic test_slow_engine;
        foreach (hts[i]) begin hts[i] = $urandom_range(1, 255); cls[i] = $urandom_range(1, 7); end
        run_frame("slow_engine", 0, 100, 0, 0);
    endtask

    task automatic test_back_to_back;
        run_frame("repeat_frame", 0, 1, 0, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.draw_done = 0;
        test_reset();
        test_reset_mid_wall();
        test_directed_frame();
        test_valid_gap();
        test_slow_engine();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
